// File: rtl/ddr2_ck_cke_sequencer.sv
// ddr2_ck_cke_sequencer
//
// Sequences the DDR2 memory clock pair and CKE from power-up through normal
// operation and clock-stop episodes.  The memory clock is running and stable
// before CKE goes high.  CKE is low before the clock is gated.  init_done is
// then raised to the DDR2 init/command controller.
//
// Ports
//   clk         controller clock, same clock as the clock output stage
//   rst_n       synchronous reset, active-low
//   clk_locked  PLL/DCM lock, synchronous to clk
//   stop_req    level request to stop the memory clock
//   ck_en       per-lane memory clock enable (1 = toggling)
//   ddr_cke     DDR2 CKE
//   init_done   power-up sequence complete
//   stop_ack    high while the clock is stopped or restarting
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_LOCK  | clock gated, CKE low, waiting for the PLL to lock
// STABLE     | clock running with CKE low for STABLE_CYCLES
// CKE_WAIT   | CKE high, waiting CKE_DLY_CYCLES before init_done
// RUN        | normal operation, honours stop_req
// STOP_CKE   | CKE low with clock still running for STOP_DLY_CYCLES
// STOPPED    | clock gated, waits for stop_req to drop
// RESTART    | clock running with CKE low for RESTART_DLY_CYCLES

module ddr2_ck_cke_sequencer #(
    parameter int CLK_WIDTH          = 1,
    parameter int STABLE_CYCLES      = 40000,
    parameter int CKE_DLY_CYCLES     = 80,
    parameter int STOP_DLY_CYCLES    = 8,
    parameter int RESTART_DLY_CYCLES = 8,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_locked,
    input  logic                 stop_req,
    output logic [CLK_WIDTH-1:0] ck_en,
    output logic                 ddr_cke,
    output logic                 init_done,
    output logic                 stop_ack
);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABLE    = 3'd1;
    localparam logic [2:0] CKE_WAIT  = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] STOP_CKE  = 3'd4;
    localparam logic [2:0] STOPPED   = 3'd5;
    localparam logic [2:0] RESTART   = 3'd6;

    // Terminal counts: a timed state lasting N cycles exits when cnt == N-1.
    localparam logic [CNT_WIDTH-1:0] STABLE_TC  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CKE_TC     = CNT_WIDTH'(CKE_DLY_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STOP_TC    = CNT_WIDTH'(STOP_DLY_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RESTART_TC = CNT_WIDTH'(RESTART_DLY_CYCLES - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [CNT_WIDTH-1:0] cnt_tc;
    logic                 timer_done;

    logic [CLK_WIDTH-1:0] ck_en_nxt;
    logic                 ddr_cke_nxt;
    logic                 init_done_nxt;
    logic                 stop_ack_nxt;

    always_comb begin
        cnt_tc = '0;
        case (state)
            STABLE:   cnt_tc = STABLE_TC;
            CKE_WAIT: cnt_tc = CKE_TC;
            STOP_CKE: cnt_tc = STOP_TC;
            RESTART:  cnt_tc = RESTART_TC;
            default:  cnt_tc = '0;
        endcase
    end

    assign timer_done = (cnt == cnt_tc);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_WIDTH'(1);
        if (!clk_locked) begin
            // Lock loss overrides everything except reset and abandons any count.
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end
                STABLE: begin
                    if (timer_done) begin
                        state_nxt = CKE_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                CKE_WAIT: begin
                    if (timer_done) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                RUN: begin
                    cnt_nxt = '0;
                    if (stop_req) begin
                        state_nxt = STOP_CKE;
                    end
                end
                STOP_CKE: begin
                    // Not abortable: a dropped stop_req is honoured from STOPPED.
                    if (timer_done) begin
                        state_nxt = STOPPED;
                        cnt_nxt   = '0;
                    end
                end
                STOPPED: begin
                    cnt_nxt = '0;
                    if (!stop_req) begin
                        state_nxt = RESTART;
                    end
                end
                RESTART: begin
                    if (timer_done) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they always
    // match the state register without a combinational output path.
    always_comb begin
        ck_en_nxt     = '0;
        ddr_cke_nxt   = 1'b0;
        init_done_nxt = 1'b0;
        stop_ack_nxt  = 1'b0;
        case (state_nxt)
            STABLE: begin
                ck_en_nxt = '1;
            end
            CKE_WAIT: begin
                ck_en_nxt   = '1;
                ddr_cke_nxt = 1'b1;
            end
            RUN: begin
                ck_en_nxt     = '1;
                ddr_cke_nxt   = 1'b1;
                init_done_nxt = 1'b1;
            end
            STOP_CKE: begin
                ck_en_nxt     = '1;
                init_done_nxt = 1'b1;
            end
            STOPPED: begin
                init_done_nxt = 1'b1;
                stop_ack_nxt  = 1'b1;
            end
            RESTART: begin
                ck_en_nxt     = '1;
                init_done_nxt = 1'b1;
                stop_ack_nxt  = 1'b1;
            end
            default: begin
                ck_en_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            ck_en     <= '0;
            ddr_cke   <= 1'b0;
            init_done <= 1'b0;
            stop_ack  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ck_en     <= ck_en_nxt;
            ddr_cke   <= ddr_cke_nxt;
            init_done <= init_done_nxt;
            stop_ack  <= stop_ack_nxt;
        end
    end

endmodule

// File: tb/tb_ddr2_ck_cke_sequencer.sv
// Bench for ddr2_ck_cke_sequencer.  Two instances share the stimulus:
// "a" uses short delays (STABLE=10, CKE=4, STOP=3, RESTART=2, two lanes),
// "b" uses the degenerate one-cycle delays.  Both are checked every cycle
// against an elapsed-time reference model; directed tables and sequences
// pin down the exact timings.
module tb_ddr2_ck_cke_sequencer;

    localparam int A_ST = 10;
    localparam int A_CK = 4;
    localparam int A_SD = 3;
    localparam int A_RS = 2;

    localparam int PH_OFF  = 0;  // clock gated, waiting for lock
    localparam int PH_PWR  = 1;  // t = cycles since lock seen (stable + CKE delay)
    localparam int PH_RUN  = 2;
    localparam int PH_STOP = 3;  // t = cycles since stop began, saturates at stop delay
    localparam int PH_WAKE = 4;  // t = cycles since wake began

    typedef struct {
        int ph;
        int t;
    } mdl_t;

    typedef struct {
        bit         rst_n;
        bit         lock;
        bit         stop;
        int         n;
        logic [1:0] ck;
        bit         cke;
        bit         done;
        bit         ack;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       clk_locked;
    logic       stop_req;
    logic [1:0] a_ck_en;
    logic       a_cke, a_done, a_ack;
    logic [0:0] b_ck_en;
    logic       b_cke, b_done, b_ack;

    int   n_cmp;
    int   n_mis;
    mdl_t ma, mb;
    vec_t vt[$];

    int         a_cke_low, a_ck_on;
    logic [1:0] a_prev_ck;
    logic       a_prev_cke, a_prev_done;

    ddr2_ck_cke_sequencer #(
        .CLK_WIDTH(2), .STABLE_CYCLES(A_ST), .CKE_DLY_CYCLES(A_CK),
        .STOP_DLY_CYCLES(A_SD), .RESTART_DLY_CYCLES(A_RS), .CNT_WIDTH(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_locked(clk_locked), .stop_req(stop_req),
        .ck_en(a_ck_en), .ddr_cke(a_cke), .init_done(a_done), .stop_ack(a_ack)
    );

    ddr2_ck_cke_sequencer #(
        .CLK_WIDTH(1), .STABLE_CYCLES(1), .CKE_DLY_CYCLES(1),
        .STOP_DLY_CYCLES(1), .RESTART_DLY_CYCLES(1), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_locked(clk_locked), .stop_req(stop_req),
        .ck_en(b_ck_en), .ddr_cke(b_cke), .init_done(b_done), .stop_ack(b_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mdl_t mdl_step(mdl_t m, bit r, bit l, bit s,
                                      int ps, int pc, int pd, int pr);
        mdl_t n;
        n = m;
        if (!r || !l) begin
            n.ph = PH_OFF;
            n.t  = 0;
        end else begin
            case (m.ph)
                PH_OFF: begin n.ph = PH_PWR; n.t = 0; end
                PH_PWR: begin
                    if (m.t == ps + pc - 1) begin n.ph = PH_RUN; n.t = 0; end
                    else n.t = m.t + 1;
                end
                PH_RUN: if (s) begin n.ph = PH_STOP; n.t = 0; end
                PH_STOP: begin
                    if (m.t < pd) n.t = m.t + 1;
                    else if (!s) begin n.ph = PH_WAKE; n.t = 0; end
                end
                default: begin
                    if (m.t == pr - 1) begin n.ph = PH_RUN; n.t = 0; end
                    else n.t = m.t + 1;
                end
            endcase
        end
        return n;
    endfunction

    // {clock on, cke, init_done, stop_ack}
    function automatic logic [3:0] mdl_out(mdl_t m, int ps, int pd);
        case (m.ph)
            PH_PWR:  return {1'b1, (m.t >= ps), 1'b0, 1'b0};
            PH_RUN:  return 4'b1110;
            PH_STOP: return {(m.t < pd), 1'b0, 1'b1, (m.t >= pd)};
            PH_WAKE: return 4'b1011;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lim);
        n_cmp++;
        if (act < lim) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected at least %0d at %0t", name, act, lim, $time);
        end
    endtask

    task automatic tick();
        logic [3:0] ea, eb;
        @(posedge clk);
        ma = mdl_step(ma, rst_n, clk_locked, stop_req, A_ST, A_CK, A_SD, A_RS);
        mb = mdl_step(mb, rst_n, clk_locked, stop_req, 1, 1, 1, 1);
        @(negedge clk);
        ea = mdl_out(ma, A_ST, A_SD);
        eb = mdl_out(mb, 1, 1);
        chk("mdl_a_ck_en", a_ck_en, {2{ea[3]}});
        chk("mdl_a_cke",   a_cke,   ea[2]);
        chk("mdl_a_done",  a_done,  ea[1]);
        chk("mdl_a_ack",   a_ack,   ea[0]);
        chk("mdl_b_ck_en", b_ck_en, eb[3]);
        chk("mdl_b_cke",   b_cke,   eb[2]);
        chk("mdl_b_done",  b_done,  eb[1]);
        chk("mdl_b_ack",   b_ack,   eb[0]);
        if (a_cke) chk("inv_cke_needs_ck", a_ck_en, 2'b11);
        if (b_cke) chk("inv_b_cke_needs_ck", b_ck_en, 1'b1);
        if (a_prev_ck == 2'b11 && a_ck_en == 2'b00 && a_prev_done && a_done)
            chk_ge("inv_stop_dly", a_cke_low, A_SD);
        if (!a_prev_cke && a_cke)
            chk_ge("inv_restart_dly", a_ck_on, a_done ? A_RS : A_ST);
        a_cke_low   = a_cke ? 0 : a_cke_low + 1;
        a_ck_on     = (a_ck_en == 2'b11) ? a_ck_on + 1 : 0;
        a_prev_ck   = a_ck_en;
        a_prev_cke  = a_cke;
        a_prev_done = a_done;
    endtask

    task automatic add(input bit r, input bit l, input bit s, input int n,
                       input logic [1:0] ck, input bit cke, input bit done, input bit ack);
        vec_t v;
        v.rst_n = r; v.lock = l; v.stop = s; v.n = n;
        v.ck = ck; v.cke = cke; v.done = done; v.ack = ack;
        vt.push_back(v);
    endtask

    // Starts with lock high and the DUT about to enter STABLE on the next edge.
    task automatic powerup_check(input string tag);
        for (int i = 1; i <= A_ST + A_CK + 1; i++) begin
            tick();
            chk({tag, "_ck"},   a_ck_en, 2'b11);
            chk({tag, "_cke"},  a_cke,   (i > A_ST) ? 1 : 0);
            chk({tag, "_done"}, a_done,  (i > A_ST + A_CK) ? 1 : 0);
        end
    endtask

    initial begin
        logic [3:0] bexp [7];
        bit         bstop [7];

        n_cmp = 0; n_mis = 0;
        ma.ph = PH_OFF; ma.t = 0;
        mb.ph = PH_OFF; mb.t = 0;
        a_cke_low = 0; a_ck_on = 0;
        a_prev_ck = 2'b00; a_prev_cke = 1'b0; a_prev_done = 1'b0;
        rst_n = 1'b0; clk_locked = 1'b0; stop_req = 1'b0;

        // rst, lock, stop, cycles, ck_en, cke, done, ack
        add(0, 0, 0,  3, 2'b00, 0, 0, 0);
        add(1, 0, 0,  2, 2'b00, 0, 0, 0);
        add(1, 1, 0, 10, 2'b11, 0, 0, 0);
        add(1, 1, 0,  4, 2'b11, 1, 0, 0);
        add(1, 1, 0,  3, 2'b11, 1, 1, 0);
        add(1, 1, 1,  3, 2'b11, 0, 1, 0);
        add(1, 1, 1,  2, 2'b00, 0, 1, 1);
        add(1, 1, 0,  2, 2'b11, 0, 1, 1);
        add(1, 1, 0,  2, 2'b11, 1, 1, 0);
        add(1, 1, 1,  1, 2'b11, 0, 1, 0);
        add(1, 1, 0,  2, 2'b11, 0, 1, 0);
        add(1, 1, 0,  1, 2'b00, 0, 1, 1);
        add(1, 1, 0,  2, 2'b11, 0, 1, 1);
        add(1, 1, 0,  1, 2'b11, 1, 1, 0);
        add(1, 0, 0,  2, 2'b00, 0, 0, 0);

        foreach (vt[v]) begin
            rst_n = vt[v].rst_n; clk_locked = vt[v].lock; stop_req = vt[v].stop;
            for (int k = 0; k < vt[v].n; k++) begin
                tick();
                chk("tbl_ck_en", a_ck_en, vt[v].ck);
                chk("tbl_cke",   a_cke,   vt[v].cke);
                chk("tbl_done",  a_done,  vt[v].done);
                chk("tbl_ack",   a_ack,   vt[v].ack);
            end
        end

        // Lock loss during CKE_WAIT, then full re-sequence.
        clk_locked = 1'b1;
        for (int i = 0; i < A_ST + 2; i++) tick();
        chk("ckewait_cke", a_cke, 1);
        clk_locked = 1'b0;
        tick();
        chk("ckewait_loss_ck", a_ck_en, 2'b00);
        chk("ckewait_loss_cke", a_cke, 0);
        clk_locked = 1'b1;
        powerup_check("relock1");

        // Lock loss while STOPPED.
        stop_req = 1'b1;
        for (int i = 0; i < A_SD + 1; i++) tick();
        chk("stopped_ack", a_ack, 1);
        chk("stopped_ck", a_ck_en, 2'b00);
        clk_locked = 1'b0;
        tick();
        chk("stopped_loss_done", a_done, 0);
        chk("stopped_loss_ack", a_ack, 0);
        clk_locked = 1'b1;
        stop_req = 1'b0;
        powerup_check("relock2");

        // Synchronous reset in RUN: nothing changes until the edge.
        rst_n = 1'b0;
        #2;
        chk("srst_no_async_done", a_done, 1);
        chk("srst_no_async_cke", a_cke, 1);
        tick();
        chk("srst_ck", a_ck_en, 2'b00);
        chk("srst_done", a_done, 0);
        rst_n = 1'b1;
        powerup_check("srst_rerun");

        // Degenerate one-cycle delays; stop_req held high through power-up.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bexp[0] = 4'b1000; bstop[0] = 1;
        bexp[1] = 4'b1100; bstop[1] = 1;
        bexp[2] = 4'b1110; bstop[2] = 1;
        bexp[3] = 4'b1010; bstop[3] = 1;
        bexp[4] = 4'b0011; bstop[4] = 0;
        bexp[5] = 4'b1011; bstop[5] = 0;
        bexp[6] = 4'b1110; bstop[6] = 0;
        stop_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("degen_b", {b_ck_en, b_cke, b_done, b_ack}, bexp[i]);
            stop_req = bstop[i];
        end

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 4000; i++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            clk_locked = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 5) == 0) stop_req = ~stop_req;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
